// File: rtl/booth_encode_2bit_nbit_pkg.sv
// Shared types for the radix-4 Booth recoder: one recoded digit as sign + 2-bit magnitude.
package booth_encode_2bit_nbit_pkg;

  localparam int N_DEFAULT = 32;

  typedef struct packed {
    logic sign;
    logic mag_hi;
    logic mag_lo;
  } booth_digit_t;

endpackage

// File: rtl/booth_encode_2bit_nbit_digit_r4.sv
// One radix-4 Booth digit: triplet {b[2j+1], b[2j], b[2j-1]} -> sign + magnitude select.
module booth_digit_r4
  import booth_encode_2bit_nbit_pkg::*;
(
  input  logic [2:0]   triplet,
  output booth_digit_t digit
);

  always_comb begin
    // NOTE: default first so every path assigns digit; no latch can be inferred.
    digit = '0;
    unique case (triplet)
      3'b001, 3'b010: digit = '{sign: 1'b0, mag_hi: 1'b0, mag_lo: 1'b1};
      3'b011:         digit = '{sign: 1'b0, mag_hi: 1'b1, mag_lo: 1'b0};
      3'b100:         digit = '{sign: 1'b1, mag_hi: 1'b1, mag_lo: 1'b0};
      3'b101, 3'b110: digit = '{sign: 1'b1, mag_hi: 1'b0, mag_lo: 1'b1};
      default:        digit = '0;  // 000 and 111 are zero, never negative zero
    endcase
  end

endmodule

// File: rtl/booth_encode_2bit_nbit.sv
// Radix-4 Booth recoder: signed N-bit operand -> N/2 digits, registered one stage.
module booth_encode_2bit_nbit
  import booth_encode_2bit_nbit_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           a_valid,
  input  logic [N-1:0]   a,
  output logic           digit_valid,
  output logic [N/2-1:0] sign,
  output logic [N/2-1:0] mag_hi,
  output logic [N/2-1:0] mag_lo
);

  localparam int D = N / 2;

  // Bit 0 stands in for a[-1], which is always zero.
  logic [N:0]   a_ext;
  logic [D-1:0] nxt_sign, nxt_mag_hi, nxt_mag_lo;

  assign a_ext = {a, 1'b0};

  for (genvar j = 0; j < D; j++) begin : g_digit
    booth_digit_t enc;

    booth_digit_r4 u_digit (
      .triplet (a_ext[2*j+2 : 2*j]),
      .digit   (enc)
    );

    assign nxt_sign[j]   = enc.sign;
    assign nxt_mag_hi[j] = enc.mag_hi;
    assign nxt_mag_lo[j] = enc.mag_lo;
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      digit_valid <= 1'b0;
      sign        <= '0;
      mag_hi      <= '0;
      mag_lo      <= '0;
    end else begin
      digit_valid <= a_valid;
      if (a_valid) begin
        sign   <= nxt_sign;
        mag_hi <= nxt_mag_hi;
        mag_lo <= nxt_mag_lo;
      end
    end
  end

endmodule

// File: tb/tb_booth_encode_2bit_nbit.sv
// Self-checking bench for booth_encode_2bit_nbit: directed corners plus a random stream vs. an arithmetic model.
module tb_booth_encode_2bit_nbit;

  localparam int N = 32;
  localparam int D = N / 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         a_valid;
  logic [N-1:0] a;
  logic         digit_valid;
  logic [D-1:0] sign, mag_hi, mag_lo;

  int n_checks = 0;
  int n_fails  = 0;

  // Model state: what the outputs should currently show.
  logic         exp_valid;
  logic [D-1:0] exp_sign, exp_hi, exp_lo;
  logic [N-1:0] last_a;

  booth_encode_2bit_nbit #(.N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .a_valid     (a_valid),
    .a           (a),
    .digit_valid (digit_valid),
    .sign        (sign),
    .mag_hi      (mag_hi),
    .mag_lo      (mag_lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Digit value straight from the recoding rule: -2*b[2j+1] + b[2j] + b[2j-1].
  task automatic model_enc(input logic [N-1:0] x,
                           output logic [D-1:0] s, output logic [D-1:0] hi, output logic [D-1:0] lo);
    for (int j = 0; j < D; j++) begin
      int v, m;
      v = -2 * int'(x[2*j+1]) + int'(x[2*j]) + ((j == 0) ? 0 : int'(x[2*j-1]));
      m = (v < 0) ? -v : v;
      s[j]  = (v < 0);
      hi[j] = m[1];
      lo[j] = m[0];
    end
  endtask

  function automatic longint recon(input logic [D-1:0] s, input logic [D-1:0] hi, input logic [D-1:0] lo);
    longint sum = 0;
    for (int j = 0; j < D; j++) begin
      longint mag = longint'({hi[j], lo[j]}) * (longint'(1) << (2 * j));
      sum += s[j] ? -mag : mag;
    end
    return sum;
  endfunction

  task automatic step(input logic r, input logic v, input logic [N-1:0] x, input string tag);
    longint want;
    rst = r; a_valid = v; a = x;
    @(posedge clk);
    #1;
    if (r) begin
      exp_valid = 1'b0; exp_sign = '0; exp_hi = '0; exp_lo = '0;
    end else begin
      exp_valid = v;
      if (v) begin
        model_enc(x, exp_sign, exp_hi, exp_lo);
        last_a = x;
      end
    end
    check({tag, ".valid"},  64'(digit_valid), 64'(exp_valid));
    check({tag, ".sign"},   64'(sign),        64'(exp_sign));
    check({tag, ".mag_hi"}, 64'(mag_hi),      64'(exp_hi));
    check({tag, ".mag_lo"}, 64'(mag_lo),      64'(exp_lo));
    check({tag, ".mag3"},   64'(mag_hi & mag_lo), 64'(0));
    check({tag, ".negzero"}, 64'(sign & ~(mag_hi | mag_lo)), 64'(0));
    if (exp_valid) begin
      want = longint'($signed(last_a));
      check({tag, ".sum"}, recon(sign, mag_hi, mag_lo), want);
    end
  endtask

  initial begin
    logic r, v;
    logic [N-1:0] x;

    exp_valid = 1'b0; exp_sign = '0; exp_hi = '0; exp_lo = '0; last_a = '0;
    rst = 1'b1; a_valid = 1'b0; a = '0;
    step(1'b1, 1'b0, '0, "reset0");
    step(1'b1, 1'b1, 32'h1234_5678, "reset_prio");

    // Directed corners with hand-derived digit vectors.
    step(1'b0, 1'b1, 32'h0000_0000, "zero");
    check("zero.direct", 64'({sign, mag_hi, mag_lo}), 64'(0));
    step(1'b0, 1'b1, 32'h0000_0002, "two");
    check("two.direct", 64'({sign, mag_hi, mag_lo}), 64'({16'h0001, 16'h0001, 16'h0002}));
    step(1'b0, 1'b1, 32'hFFFF_FFFF, "minus1");
    check("minus1.direct", 64'({sign, mag_hi, mag_lo}), 64'({16'h0001, 16'h0000, 16'h0001}));
    step(1'b0, 1'b1, 32'h7FFF_FFFF, "maxpos");
    check("maxpos.direct", 64'({sign, mag_hi, mag_lo}), 64'({16'h0001, 16'h8000, 16'h0001}));
    step(1'b0, 1'b1, 32'h8000_0000, "minneg");
    check("minneg.direct", 64'({sign, mag_hi, mag_lo}), 64'({16'h8000, 16'h8000, 16'h0000}));

    // Hold: data keeps the last encoding, valid drops.
    step(1'b0, 1'b0, 32'h5555_5555, "hold");
    check("hold.direct", 64'({sign, mag_hi, mag_lo}), 64'({16'h8000, 16'h8000, 16'h0000}));

    // Random stream with occasional idle cycles and mid-stream resets.
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 99) < 3);
      v = ($urandom_range(0, 99) < 85);
      x = $urandom;
      step(r, v, x, r ? "rand_rst" : "rand");
      if (r) check("rand_rst.zero", 64'({digit_valid, sign, mag_hi, mag_lo}), 64'(0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
